// File: rtl/i2c_shift_unit.sv
// i2c_shift_unit
// Serial data unit for the I2C master. Shifts a DATA_W-bit word out on SDA
// (transmit) or in from SDA (receive), then services the 9th-clock
// acknowledge slot and reports completion with a one-cycle done pulse.
//
// Parameters
//   DATA_W     word width in bits (>= 2)
//   MSB_FIRST  1 = MSB shifted first (I2C standard), 0 = LSB first
//
// Ports
//   clk_i        system clock, rising edge
//   reset_i      synchronous active-high reset
//   start_i      one-cycle transfer request, honoured only in IDLE
//   mode_i       0 = transmit, 1 = receive (sampled with start_i)
//   data_i       transmit word (sampled with start_i)
//   send_nack_i  receive: 1 = NACK in ACK slot, 0 = ACK (sampled with start_i)
//   scl_rise_i   SCL rising-edge strobe (sample point)
//   scl_fall_i   SCL falling-edge strobe (change point)
//   sda_in_i     synchronised SDA level
//   sda_out_o    SDA drive value, meaningful while sda_oe_o = 1
//   sda_oe_o     1 = drive SDA, 0 = release
//   rx_data_o    last completed received word
//   ack_rcvd_o   transmit: SDA level sampled in ACK slot (0 = ACK)
//   busy_o       transfer in progress
//   done_o       one-cycle pulse after the ACK slot
//   state_o      debug view of the FSM state (0 IDLE, 1 DATA, 2 ACK, 3 DONE)
//   bit_cnt_o    debug view of the bit counter
//
// Handshake: start_i is a single-cycle request; it is consumed only when
// busy_o = 0 and done_o = 0 (IDLE). Completion is the done_o pulse, which
// coincides with busy_o falling.
//
// Every output is a register loaded from the next-state values, so no input
// reaches an output combinationally.
module i2c_shift_unit #(
    parameter int   DATA_W    = 8,
    parameter bit   MSB_FIRST = 1'b1,
    localparam int  CNT_W     = $clog2(DATA_W)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              mode_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              send_nack_i,
    input  logic              scl_rise_i,
    input  logic              scl_fall_i,
    input  logic              sda_in_i,
    output logic              sda_out_o,
    output logic              sda_oe_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              ack_rcvd_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [1:0]        state_o,
    output logic [CNT_W-1:0]  bit_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_ACK  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                mode_q, mode_d;
    logic                nack_q, nack_d;
    logic [DATA_W-1:0]   rx_data_q, rx_data_d;
    logic                ack_q, ack_d;
    logic                sda_out_q, sda_out_d;
    logic                sda_oe_q, sda_oe_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                strobe_clash;
    logic                tx_bit_d;

    // Both strobes in one cycle cannot happen on a real bus; treat the cycle
    // as a no-op so a glitching controller cannot corrupt the word.
    assign strobe_clash = scl_rise_i & scl_fall_i;

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        nack_d    = nack_q;
        rx_data_d = rx_data_q;
        ack_d     = ack_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_DATA;
                    shreg_d = mode_i ? '0 : data_i;
                    mode_d  = mode_i;
                    nack_d  = send_nack_i;
                    cnt_d   = '0;
                end
            end
            S_DATA: begin
                if (!strobe_clash) begin
                    if (!mode_q) begin
                        if (scl_fall_i) begin
                            if (cnt_q == LAST_BIT) begin
                                state_d = S_ACK;
                                cnt_d   = '0;
                            end else begin
                                cnt_d = cnt_q + CNT_W'(1);
                                if (MSB_FIRST) shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
                                else           shreg_d = {1'b0, shreg_q[DATA_W-1:1]};
                            end
                        end
                    end else begin
                        if (scl_rise_i) begin
                            if (MSB_FIRST) shreg_d = {shreg_q[DATA_W-2:0], sda_in_i};
                            else           shreg_d = {sda_in_i, shreg_q[DATA_W-1:1]};
                        end
                        if (scl_fall_i) begin
                            if (cnt_q == LAST_BIT) begin
                                state_d   = S_ACK;
                                cnt_d     = '0;
                                rx_data_d = shreg_q;
                            end else begin
                                cnt_d = cnt_q + CNT_W'(1);
                            end
                        end
                    end
                end
            end
            S_ACK: begin
                if (!strobe_clash) begin
                    if (!mode_q && scl_rise_i) ack_d = sda_in_i;
                    if (scl_fall_i) state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;  // S_DONE: start is ignored here
        endcase

        // Output registers are loaded from the next state so they line up
        // with it in the following cycle.
        tx_bit_d  = MSB_FIRST ? shreg_d[DATA_W-1] : shreg_d[0];
        sda_oe_d  = ((state_d == S_DATA) && !mode_d) || ((state_d == S_ACK) && mode_d);
        sda_out_d = 1'b1;
        if ((state_d == S_DATA) && !mode_d) sda_out_d = tx_bit_d;
        if ((state_d == S_ACK) && mode_d)   sda_out_d = nack_d;
        busy_d    = (state_d == S_DATA) || (state_d == S_ACK);
        done_d    = (state_d == S_DONE);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            shreg_q   <= '0;
            cnt_q     <= '0;
            mode_q    <= 1'b0;
            nack_q    <= 1'b0;
            rx_data_q <= '0;
            ack_q     <= 1'b0;
            sda_out_q <= 1'b1;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            nack_q    <= nack_d;
            rx_data_q <= rx_data_d;
            ack_q     <= ack_d;
            sda_out_q <= sda_out_d;
            sda_oe_q  <= sda_oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign sda_out_o  = sda_out_q;
    assign sda_oe_o   = sda_oe_q;
    assign rx_data_o  = rx_data_q;
    assign ack_rcvd_o = ack_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign state_o    = state_q;
    assign bit_cnt_o  = cnt_q;

endmodule

// File: tb/tb_i2c_shift_unit.sv
// Directed testbench for i2c_shift_unit. Three instances share one set of
// stimulus: 8-bit MSB-first, 8-bit LSB-first and 12-bit MSB-first. Each test
// resets all of them first and then observes the instance selected by sel.
// Inputs change on the falling clock edge; outputs are read there too.
module tb_i2c_shift_unit;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        start_i = 1'b0;
    logic        mode_i = 1'b0;
    logic [11:0] data_i = '0;
    logic        send_nack_i = 1'b0;
    logic        scl_rise_i = 1'b0;
    logic        scl_fall_i = 1'b0;
    logic        sda_in_i = 1'b1;

    logic        a_sda_out, a_sda_oe, a_ack, a_busy, a_done;
    logic [7:0]  a_rx;
    logic [1:0]  a_state;
    logic [2:0]  a_cnt;
    logic        b_sda_out, b_sda_oe, b_ack, b_busy, b_done;
    logic [7:0]  b_rx;
    logic [1:0]  b_state;
    logic [2:0]  b_cnt;
    logic        c_sda_out, c_sda_oe, c_ack, c_busy, c_done;
    logic [11:0] c_rx;
    logic [1:0]  c_state;
    logic [3:0]  c_cnt;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int          sel = 0;

    logic        o_sda_out, o_sda_oe, o_ack, o_busy, o_done;
    logic [11:0] o_rx;
    logic [1:0]  o_state;
    logic [3:0]  o_cnt;

    always #5 clk = ~clk;

    i2c_shift_unit #(.DATA_W(8), .MSB_FIRST(1'b1)) u_msb8 (
        .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .mode_i(mode_i),
        .data_i(data_i[7:0]), .send_nack_i(send_nack_i), .scl_rise_i(scl_rise_i),
        .scl_fall_i(scl_fall_i), .sda_in_i(sda_in_i), .sda_out_o(a_sda_out),
        .sda_oe_o(a_sda_oe), .rx_data_o(a_rx), .ack_rcvd_o(a_ack), .busy_o(a_busy),
        .done_o(a_done), .state_o(a_state), .bit_cnt_o(a_cnt));

    i2c_shift_unit #(.DATA_W(8), .MSB_FIRST(1'b0)) u_lsb8 (
        .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .mode_i(mode_i),
        .data_i(data_i[7:0]), .send_nack_i(send_nack_i), .scl_rise_i(scl_rise_i),
        .scl_fall_i(scl_fall_i), .sda_in_i(sda_in_i), .sda_out_o(b_sda_out),
        .sda_oe_o(b_sda_oe), .rx_data_o(b_rx), .ack_rcvd_o(b_ack), .busy_o(b_busy),
        .done_o(b_done), .state_o(b_state), .bit_cnt_o(b_cnt));

    i2c_shift_unit #(.DATA_W(12), .MSB_FIRST(1'b1)) u_msb12 (
        .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .mode_i(mode_i),
        .data_i(data_i), .send_nack_i(send_nack_i), .scl_rise_i(scl_rise_i),
        .scl_fall_i(scl_fall_i), .sda_in_i(sda_in_i), .sda_out_o(c_sda_out),
        .sda_oe_o(c_sda_oe), .rx_data_o(c_rx), .ack_rcvd_o(c_ack), .busy_o(c_busy),
        .done_o(c_done), .state_o(c_state), .bit_cnt_o(c_cnt));

    always_comb begin
        o_sda_out = c_sda_out; o_sda_oe = c_sda_oe; o_ack = c_ack;
        o_busy = c_busy; o_done = c_done; o_rx = c_rx;
        o_state = c_state; o_cnt = c_cnt;
        if (sel == 0) begin
            o_sda_out = a_sda_out; o_sda_oe = a_sda_oe; o_ack = a_ack;
            o_busy = a_busy; o_done = a_done; o_rx = {4'b0, a_rx};
            o_state = a_state; o_cnt = {1'b0, a_cnt};
        end else if (sel == 1) begin
            o_sda_out = b_sda_out; o_sda_oe = b_sda_oe; o_ack = b_ack;
            o_busy = b_busy; o_done = b_done; o_rx = {4'b0, b_rx};
            o_state = b_state; o_cnt = {1'b0, b_cnt};
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_i = 1'b1; start_i = 1'b0; scl_rise_i = 1'b0; scl_fall_i = 1'b0;
        @(negedge clk);
        reset_i = 1'b0;
    endtask

    task automatic pulse_rise(input logic b);
        @(negedge clk);
        sda_in_i = b; scl_rise_i = 1'b1;
        @(negedge clk);
        scl_rise_i = 1'b0;
    endtask

    task automatic pulse_fall();
        @(negedge clk);
        scl_fall_i = 1'b1;
        @(negedge clk);
        scl_fall_i = 1'b0;
    endtask

    task automatic start_word(input logic m, input logic [11:0] d, input logic nack);
        @(negedge clk);
        start_i = 1'b1; mode_i = m; data_i = d; send_nack_i = nack;
        @(negedge clk);
        start_i = 1'b0; data_i = '0; mode_i = 1'b0; send_nack_i = 1'b0;
        check("busy after start", o_busy, 1);
    endtask

    // DONE cycle checks, plus a start pulse there that must be ignored.
    task automatic finish_checks();
        check("done pulse", o_done, 1);
        check("busy low at done", o_busy, 0);
        check("sda_oe at done", o_sda_oe, 0);
        check("sda_out at done", o_sda_out, 1);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check("done single", o_done, 0);
        check("start in done ignored", o_busy, 0);
        check("idle after done", o_state, 0);
    endtask

    task automatic run_tx(input int w, input bit msb, input logic [11:0] d,
                          input logic slave_ack, input bit disturb);
        logic exp_bit;
        start_word(1'b0, d, 1'b0);
        for (int i = 0; i < w; i++) begin
            exp_bit = msb ? d[w-1-i] : d[i];
            check($sformatf("tx oe bit %0d", i), o_sda_oe, 1);
            check($sformatf("tx bit %0d", i), o_sda_out, exp_bit);
            if (disturb && i == 3) begin
                // Foreign start plus clashing strobes: nothing may change.
                @(negedge clk);
                start_i = 1'b1; mode_i = 1'b1; data_i = ~d;
                scl_rise_i = 1'b1; scl_fall_i = 1'b1;
                @(negedge clk);
                start_i = 1'b0; mode_i = 1'b0; data_i = '0;
                scl_rise_i = 1'b0; scl_fall_i = 1'b0;
                check("disturb bit held", o_sda_out, exp_bit);
                check("disturb cnt held", o_cnt, 3);
            end
            pulse_rise(1'b1);
            pulse_fall();
        end
        check("tx ack oe released", o_sda_oe, 0);
        check("tx ack busy", o_busy, 1);
        check("tx ack cnt wrapped", o_cnt, 0);
        pulse_rise(slave_ack);
        check("ack_rcvd", o_ack, slave_ack);
        pulse_fall();
        finish_checks();
        check("ack_rcvd held", o_ack, slave_ack);
    endtask

    task automatic run_rx(input int w, input bit msb, input logic [11:0] word, input logic nack);
        logic [11:0] prev;
        prev = o_rx;
        start_word(1'b1, 12'h000, nack);
        for (int i = 0; i < w; i++) begin
            check($sformatf("rx oe bit %0d", i), o_sda_oe, 0);
            pulse_rise(msb ? word[w-1-i] : word[i]);
            if (i == w - 1) check("rx_data held until last fall", o_rx, prev);
            pulse_fall();
        end
        check("rx_data", o_rx, word);
        check("rx ack oe", o_sda_oe, 1);
        check("rx ack level", o_sda_out, nack);
        check("rx ack cnt wrapped", o_cnt, 0);
        pulse_rise(1'b0);
        pulse_fall();
        finish_checks();
    endtask

    initial begin
        // Reset values
        sel = 0;
        repeat (2) @(negedge clk);
        reset_i = 1'b0;
        check("rst sda_out", o_sda_out, 1);
        check("rst sda_oe", o_sda_oe, 0);
        check("rst rx_data", o_rx, 0);
        check("rst ack_rcvd", o_ack, 0);
        check("rst busy", o_busy, 0);
        check("rst done", o_done, 0);

        // 8-bit MSB-first transmit of 0xA5 with disturbances, slave ACKs
        do_reset();
        run_tx(8, 1'b1, 12'h0A5, 1'b0, 1'b1);

        // 8-bit receive: bits 0,0,1,1,1,1,0,0 -> 0x3C, master NACKs
        run_rx(8, 1'b1, 12'h03C, 1'b1);

        // Reset after the 4th received bit, then a clean receive
        start_word(1'b1, 12'h000, 1'b0);
        for (int i = 0; i < 4; i++) begin
            pulse_rise(1'b1);
            pulse_fall();
        end
        @(negedge clk);
        reset_i = 1'b1;
        @(negedge clk);
        check("midrst sda_out", o_sda_out, 1);
        check("midrst sda_oe", o_sda_oe, 0);
        check("midrst rx_data cleared", o_rx, 0);
        check("midrst busy", o_busy, 0);
        check("midrst done", o_done, 0);
        check("midrst state", o_state, 0);
        check("midrst cnt", o_cnt, 0);
        reset_i = 1'b0;
        run_rx(8, 1'b1, 12'h05A, 1'b0);

        // LSB-first transmit of 0x01, slave NACKs: 1 then seven 0s
        do_reset();
        sel = 1;
        run_tx(8, 1'b0, 12'h001, 1'b1, 1'b0);

        // 12-bit transmit 0xABC then receive 0x9C3
        do_reset();
        sel = 2;
        run_tx(12, 1'b1, 12'hABC, 1'b0, 1'b0);
        run_rx(12, 1'b1, 12'h9C3, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/i2c_shift_unit.md
# i2c_shift_unit

Parametrised serial data unit for the I2C master: shifts a DATA_W-bit word out on SDA (transmit) or in from SDA (receive), then handles the 9th-clock acknowledge slot. It sits between the master controller FSM, which issues start/mode and SCL edge strobes, and the SDA pad logic, which it drives through sda_out/sda_oe. It supersedes the fixed 8-bit, transmit-only shifter by adding receive mode, bit-order selection, bit counting, ACK handling and a completion handshake.

## Interface

- DATA_W, 8, word width in bits (≥2)
- MSB_FIRST, 1, 1 = MSB shifted first (I2C standard), 0 = LSB first
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin a word transfer; sampled only in IDLE
- mode  input  1  sampled with start: 0 = transmit, 1 = receive
- data  input  DATA_W  transmit word, sampled with start
- send_nack  input  1  receive mode, sampled with start: 1 = master NACKs (SDA high) in ACK slot, 0 = ACK (SDA low)
- scl_rise  input  1  one-cycle strobe, SCL rising edge (sample point)
- scl_fall  input  1  one-cycle strobe, SCL falling edge (change point)
- sda_in  input  1  synchronised SDA line level
- sda_out  output  1  SDA drive value (meaningful when sda_oe=1)
- sda_oe  output  1  1 = drive SDA, 0 = release (open-drain high)
- rx_data  output  DATA_W  last received word, held until next receive completes
- ack_rcvd  output  1  transmit mode: SDA level sampled in ACK slot (0 = slave ACK, 1 = NACK)
- busy  output  1  high from cycle after accepted start until done
- done  output  1  one-cycle pulse at end of ACK slot

## Operation

- States: IDLE, DATA, ACK, DONE. Bit counter bit_cnt, width clog2(DATA_W), counts 0..DATA_W-1.
- IDLE: start=1 -> load shift register (data, or zeros in receive), latch mode and send_nack, bit_cnt=0, go DATA. start while not IDLE is ignored.
- DATA, transmit: sda_oe=1, sda_out = shreg[DATA_W-1] (MSB_FIRST=1) or shreg[0] (MSB_FIRST=0). On scl_fall: shift by one (left if MSB_FIRST, else right), bit_cnt+1; if bit_cnt==DATA_W-1 instead go ACK, bit_cnt=0.
- DATA, receive: sda_oe=0. On scl_rise: shift sda_in into shreg[0] (MSB_FIRST=1, shift left) or shreg[DATA_W-1] (MSB_FIRST=0, shift right). On scl_fall: bit_cnt+1; if bit_cnt==DATA_W-1 go ACK, copy shreg to rx_data on the same edge.
- ACK, transmit: sda_oe=0; on scl_rise ack_rcvd <= sda_in. Receive: sda_oe=1, sda_out=send_nack. On scl_fall go DONE.
- DONE: done=1, busy=0 for exactly one cycle; go IDLE unconditionally (start in DONE ignored).
- scl_rise and scl_fall both high in one cycle is illegal; block makes no state, counter or shift change that cycle.
- reset at any time, including mid-word, returns to IDLE with reset values below next cycle; partial rx word is discarded (rx_data cleared).

## Timing

- Reset values: sda_out=1, sda_oe=0, rx_data=0, ack_rcvd=0, busy=0, done=0; state IDLE, bit_cnt=0, shreg=0.
- All outputs registered or decoded from registered state; no combinational path from scl_rise/scl_fall/sda_in to outputs.
- start accepted at edge N -> busy=1, sda_oe/sda_out valid for first bit at N+1.
- Each bit change occurs the cycle after the scl_fall strobe; each sample uses sda_in in the scl_rise strobe cycle.
- Transfer length: DATA_W data clocks + 1 ACK clock; done asserted the cycle after the ACK-slot scl_fall, busy deasserted that same cycle.
- In IDLE and DONE: sda_oe=0, sda_out=1.
- rx_data valid from the cycle after the DATA_W-th scl_fall; ack_rcvd valid from the cycle after the ACK scl_rise, both held until overwritten.

## Test plan

- TX, DATA_W=8, MSB_FIRST=1, data=0xA5, sda_in=0 in ACK slot -> sda_out sequence 1,0,1,0,0,1,0,1 with sda_oe=1, then sda_oe=0 in ACK, ack_rcvd=0, single done pulse, busy low after.
- RX, MSB_FIRST=1, sda_in bits 0,0,1,1,1,1,0,0, send_nack=1 -> rx_data=0x3C, sda_oe=1 and sda_out=1 during ACK slot, done pulse.
- MSB_FIRST=0, TX data=0x01, slave NACK -> sda_out first bit 1 then seven 0s; ack_rcvd=1.
- DATA_W=12 TX 0xABC then RX -> 13 SCL clocks per transfer, bit_cnt wraps to 0, rx_data matches 12-bit pattern.
- reset asserted after 4th bit of RX -> next cycle all outputs at reset values, rx_data=0; new start works normally.
- start asserted while busy, and scl_rise+scl_fall asserted together mid-DATA -> both ignored, output bit stream unchanged and completes correctly.
